// File: rtl/timer_device.sv
// timer_device: memory-mapped countdown timer with one-shot and auto-reload modes.
// Define TIMER_STATUS_EN to expose a status/irq-acknowledge register at word 3.
module timer_device (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;

  logic wr;
  logic en;
  logic autoReload;

  assign wr         = sel & we;
  assign en         = ctrl_q[0];
  assign autoReload = (ctrl_q[2:1] == 2'b01);

  // FSM step first; a bus write on the same edge then overrides whatever the FSM chose.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q <= 32'd1) begin
          count_d = 32'd0;
          pend_d  = 1'b1;
          state_d = INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      INT: begin
        if (autoReload) begin
          pend_d  = 1'b0;
          state_d = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
    endcase

    if (wr) begin
      case (addr)
        2'd0: begin
          ctrl_d = din[3:0];
          pend_d = 1'b0;
        end
        2'd1: begin
          preset_d = din;
          pend_d   = 1'b0;
        end
`ifdef TIMER_STATUS_EN
        2'd3: begin
          if (din[0]) pend_d = 1'b0;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0: dout = {28'd0, ctrl_q};
      2'd1: dout = preset_q;
      2'd2: dout = count_q;
      default: begin
`ifdef TIMER_STATUS_EN
        dout = {27'd0, state_q, ctrl_q[3], ctrl_q[0], pend_q};
`else
        dout = 32'd0;
`endif
      end
    endcase
  end

  assign irq = ctrl_q[3] & pend_q;

endmodule

// File: tb/tb_timer_device.sv
// Self-checking bench for timer_device: directed scenarios followed by random bus traffic,
// all compared against an elapsed-time model of the timer.
module tb_timer_device;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  timer_device dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  // Model: a run is tracked as edges elapsed since the load cycle, against the latched preset.
  logic [3:0]  mCtrl    = 4'd0;
  logic [31:0] mPreset  = 32'd0;
  logic [31:0] mCount   = 32'd0;
  logic [31:0] mLatched = 32'd0;
  bit          mPend    = 1'b0;
  bit          mRun     = 1'b0;
  longint      mElapsed = 0;

  function automatic longint runLength();
    return (mLatched == 32'd0) ? 1 : longint'(mLatched);
  endfunction

  task automatic modelEdge(input bit rst, input bit s, input bit w,
                           input logic [1:0] a, input logic [31:0] d);
    longint len;
    bit     en;
    bit     autoMode;
    if (rst) begin
      mCtrl = 4'd0; mPreset = 32'd0; mCount = 32'd0; mLatched = 32'd0;
      mPend = 1'b0; mRun = 1'b0; mElapsed = 0;
      return;
    end
    len      = runLength();
    en       = mCtrl[0];
    autoMode = (mCtrl[2:1] == 2'b01);
    if (!mRun) begin
      if (en) begin
        mRun = 1'b1;
        mElapsed = 0;
      end
    end else if (mElapsed == 0) begin
      mCount   = mPreset;
      mLatched = mPreset;
      mElapsed = 1;
    end else if (mElapsed <= len) begin
      if (!en) begin
        mRun = 1'b0;
      end else if (mElapsed == len) begin
        mCount = 32'd0;
        mPend  = 1'b1;
        mElapsed++;
      end else begin
        mCount = mLatched - 32'(mElapsed);
        mElapsed++;
      end
    end else begin
      if (autoMode) begin
        mPend = 1'b0;
        mElapsed = 0;
      end else begin
        mCtrl[0] = 1'b0;
        mRun = 1'b0;
      end
    end
    if (s && w) begin
      case (a)
        2'd0: begin mCtrl = d[3:0]; mPend = 1'b0; end
        2'd1: begin mPreset = d; mPend = 1'b0; end
`ifdef TIMER_STATUS_EN
        2'd3: if (d[0]) mPend = 1'b0;
`endif
        default: ;
      endcase
    end
  endtask

  function automatic logic [1:0] modelStateCode();
    if (!mRun) return 2'd0;
    if (mElapsed == 0) return 2'd1;
    if (mElapsed <= runLength()) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [31:0] expDout(input logic [1:0] a);
    case (a)
      2'd0: return {28'd0, mCtrl};
      2'd1: return mPreset;
      2'd2: return mCount;
      default: begin
`ifdef TIMER_STATUS_EN
        return {27'd0, modelStateCode(), mCtrl[3], mCtrl[0], mPend};
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag);
    logic        expIrq;
    logic [31:0] expD;
    sel = 1'b0;
    we  = 1'b0;
    expIrq = mCtrl[3] & mPend;
    vectors++;
    assert (irq === expIrq) else begin
      miscompares++;
      $error("FAIL %s irq: observed %b expected %b", tag, irq, expIrq);
    end
    for (int i = 0; i < 4; i++) begin
      addr = i[1:0];
      #1;
      expD = expDout(i[1:0]);
      vectors++;
      assert (dout === expD) else begin
        miscompares++;
        $error("FAIL %s dout[addr %0d]: observed %h expected %h", tag, i, dout, expD);
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit s, input bit w,
                               input logic [1:0] a, input logic [31:0] d, input string tag);
    reset = rst; sel = s; we = w; addr = a; din = d;
    @(posedge clk);
    modelEdge(rst, s, w, a, d);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, tag);
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d, input string tag);
    applyStimulus(1'b0, 1'b1, 1'b1, a, d, tag);
  endtask

  initial begin
    int riseAt;
    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;
    #2;

    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, "reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, "reset");

    // One-shot: irq must appear exactly 7 edges after the enabling write.
    busWrite(2'd1, 32'd5, "oneshot_preset");
    busWrite(2'd0, 32'h9, "oneshot_ctrl");
    riseAt = -1;
    for (int k = 1; k <= 20 && riseAt < 0; k++) begin
      idle(1, "oneshot_run");
      if (irq === 1'b1) riseAt = k;
    end
    vectors++;
    assert (riseAt === 7) else begin
      miscompares++;
      $error("FAIL oneshot_latency: observed %0d expected %0d", riseAt, 7);
    end
    idle(4, "oneshot_hold");
    busWrite(2'd0, 32'h8, "oneshot_ack");
    idle(2, "oneshot_after");

    busWrite(2'd1, 32'd3, "auto_preset");
    busWrite(2'd0, 32'hB, "auto_ctrl");
    idle(22, "auto_run");

    busWrite(2'd0, 32'h0, "pause_stop_prev");
    busWrite(2'd1, 32'd100, "pause_preset");
    busWrite(2'd0, 32'h1, "pause_ctrl");
    idle(11, "pause_run");
    busWrite(2'd0, 32'h0, "pause_clear");
    idle(3, "pause_frozen");
    busWrite(2'd0, 32'h1, "pause_resume");
    idle(4, "pause_reload");
    busWrite(2'd0, 32'h0, "pause_end");
    idle(2, "pause_end");

    busWrite(2'd1, 32'd2, "mask_preset");
    busWrite(2'd0, 32'h1, "mask_ctrl");
    idle(8, "mask_run");
    busWrite(2'd1, 32'd0, "zero_preset");
    busWrite(2'd0, 32'h9, "zero_ctrl");
    idle(5, "zero_run");
    busWrite(2'd2, 32'h1234, "count_write");
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd0, 32'hF, "unselected_write");
    applyStimulus(1'b0, 1'b0, 1'b1, 2'd1, 32'd77, "unselected_write");

    busWrite(2'd0, 32'h0, "collide_prep");
    busWrite(2'd1, 32'd3, "collide_preset");
    busWrite(2'd0, 32'h9, "collide_ctrl");
    idle(4, "collide_run");
    busWrite(2'd0, 32'h9, "collide_expiry");
    idle(4, "collide_after");

    busWrite(2'd1, 32'd50, "rst_preset");
    busWrite(2'd0, 32'h9, "rst_ctrl");
    idle(6, "rst_run");
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, "rst_mid");
    idle(2, "rst_after");

    busWrite(2'd1, 32'd2, "status_preset");
    busWrite(2'd0, 32'h9, "status_ctrl");
    idle(6, "status_run");
    busWrite(2'd3, 32'h1, "status_ack");
    idle(2, "status_after");

    for (int n = 0; n < 400; n++) begin
      bit          rst;
      bit          s;
      bit          w;
      logic [1:0]  a;
      logic [31:0] d;
      rst = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 3) == 0);
      w   = $urandom_range(0, 1) == 1;
      a   = 2'($urandom_range(0, 3));
      d   = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      applyStimulus(rst, s, w, a, d, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
